// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Purpose  : Sums a programmed number of unsigned products into a saturating
//            accumulator and presents the result on a valid/ready output.
// Revision : 1.0
// ============================================================================
module product_accumulator #(
    parameter int W    = 16,
    parameter int ACCW = 24,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] len,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    input  logic            out_ready,
    output logic            overflow,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [ACCW:0]   w_sum;

    // One extra bit catches the carry out of the accumulator width.
    assign w_sum = {1'b0, acc_q} + {{(ACCW + 1 - W){1'b0}}, in_data};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    if (w_sum[ACCW]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = w_sum[ACCW-1:0];
                    end
                    count_d = count_q - CNTW'(1);
                    if (count_q == CNTW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output is a direct decode of registered state.
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = acc_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Directed, scoreboard-based check of product_accumulator at
//            ACCW=24 and ACCW=17.
// Revision : 1.0
// ============================================================================
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic        in_ready_a, out_valid_a, overflow_a, busy_a;
    logic [23:0] out_data_a;
    logic        in_ready_s, out_valid_s, overflow_s, busy_s;
    logic [16:0] out_data_s;

    logic        o_ready, o_valid, o_ovf, o_busy;
    logic [23:0] o_data;

    typedef struct {
        logic [23:0] data;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] prods[16];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    product_accumulator #(.W(16), .ACCW(24), .CNTW(4)) u_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .len(len),
        .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
        .overflow(overflow_a), .busy(busy_a)
    );

    product_accumulator #(.W(16), .ACCW(17), .CNTW(4)) u_s (
        .clk(clk), .rst(rst), .start(start & sel), .len(len),
        .in_valid(in_valid & sel), .in_data(in_data), .in_ready(in_ready_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
        .overflow(overflow_s), .busy(busy_s)
    );

    assign o_ready = sel ? in_ready_s  : in_ready_a;
    assign o_valid = sel ? out_valid_s : out_valid_a;
    assign o_ovf   = sel ? overflow_s  : overflow_a;
    assign o_busy  = sel ? busy_s      : busy_a;
    assign o_data  = sel ? {7'd0, out_data_s} : out_data_a;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    endtask

    // Reference sum with saturation at the accumulator width.
    function automatic exp_t model(input int n, input int accw);
        exp_t   e;
        longint acc;
        longint mx;
        mx  = (longint'(1) << accw) - 1;
        acc = 0;
        e.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += longint'(prods[i]);
            if (acc > mx) begin
                acc   = mx;
                e.ovf = 1'b1;
            end
        end
        e.data = acc[23:0];
        return e;
    endfunction

    // Run n products with `gap` idle cycles before each, then hold off the
    // consumer for `bp` cycles; if junk=1, poke start/in_valid during DONE.
    task automatic do_run(input string tag, input int n, input int gap, input int bp, input bit junk);
        exp_t e;
        int   waited;
        sb.push_back(model(n, sel ? 17 : 24));
        len   = 4'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        len   = 4'd7;
        chk({tag, "_busy"},  32'(o_busy), 32'd1);
        chk({tag, "_rdy0"},  32'(o_ready), (n != 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) tick();
            in_valid = 1'b1;
            in_data  = prods[i];
            tick();
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
        end
        chk({tag, "_vld_now"}, 32'(o_valid), 32'd1);
        chk({tag, "_rdy_off"}, 32'(o_ready), 32'd0);
        waited = 0;
        while (!o_valid && waited < 40) begin
            tick();
            waited++;
        end
        if (!o_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, 32'(o_data), 32'(e.data));
        chk({tag, "_ovf"},  32'(o_ovf),  32'(e.ovf));
        for (int b = 0; b < bp; b++) begin
            if (junk) begin
                start    = 1'b1;
                len      = 4'(b + 2);
                in_valid = 1'b1;
                in_data  = 16'h1234;
            end
            tick();
            chk({tag, "_hold_v"}, 32'(o_valid), 32'd1);
            chk({tag, "_hold_d"}, 32'(o_data),  32'(e.data));
        end
        in_valid  = 1'b0;
        start     = junk;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk_idle({tag, "_after"});
        chk({tag, "_keep_d"}, 32'(o_data), 32'(e.data));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_ovf",  32'(o_ovf),  32'd0);
        chk_idle("rst");
        rst = 1'b0;
        tick();

        // Partial run aborted by reset after two of five beats.
        len   = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_acc_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", 32'(o_data), 32'd0);
        chk_idle("arst");
        tick();
        rst = 1'b0;
        tick();

        prods[0] = 16'd3; prods[1] = 16'd4;
        do_run("post_rst", 2, 0, 0, 1'b0);

        prods[0] = 16'h0010; prods[1] = 16'h0020;
        prods[2] = 16'h0030; prods[3] = 16'h0040;
        do_run("basic", 4, 0, 0, 1'b0);

        prods[0] = 16'hFFFF; prods[1] = 16'h0001; prods[2] = 16'h0002;
        do_run("bubble_bp", 3, 2, 5, 1'b0);

        do_run("len0", 0, 0, 0, 1'b0);

        for (int i = 0; i < 15; i++) prods[i] = 16'hFFFF;
        do_run("ignored", 15, 0, 4, 1'b1);

        sel = 1'b1;
        tick();
        prods[0] = 16'hFFFF; prods[1] = 16'hFFFF; prods[2] = 16'hFFFF;
        do_run("sat", 3, 0, 0, 1'b0);
        prods[0] = 16'd5;
        do_run("sat_next", 1, 1, 1, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
